data_mem: RTL and testbench



---
 rtl/data_mem.sv | 175 +++++++++++++++++
 tb/tb_data_mem.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem.sv
// data_mem: data-side memory stage sitting behind the CPU's d$ port.
//
// Byte-addressable, little-endian storage organised as DEPTH_BYTES/8 words of
// 64 bits. Loads are combinational; stores take effect on the rising clock
// edge. Transfers of 1, 2, 4 or 8 bytes are supported, and an access must be
// naturally aligned so that it never crosses a word boundary. After reset the
// array optionally zero-fills itself one word per cycle. While that is going on
// busy is high and every access is ignored. Illegal accesses are recorded in a
// sticky error flag together with the address of the first offender.
//
// Ports
//   clk           clock, all state updates on posedge
//   rst           synchronous, active-high reset
//   address       byte address; only the low log2(DEPTH_BYTES) bits select
//   write_enable  store request this cycle
//   read_enable   load request this cycle
//   write_data    store data, LSB-aligned
//   xfer_size     transfer size in bytes (1, 2, 4 or 8)
//   read_data     load data, zero-extended, combinational
//   busy          post-reset clear in progress
//   err           sticky illegal-access flag
//   err_addr      address of the first illegal access since reset
module data_mem #(
    parameter int DEPTH_BYTES    = 1024,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] address,
    input  logic        write_enable,
    input  logic        read_enable,
    input  logic [63:0] write_data,
    input  logic [3:0]  xfer_size,
    output logic [63:0] read_data,
    output logic        busy,
    output logic        err,
    output logic [63:0] err_addr
);

    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int WORDS = DEPTH_BYTES / 8;
    // A single-word memory still needs a 1-bit pointer to stay legal SV.
    localparam int PW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          err_q;
    logic [63:0]   err_addr_q;
    logic [63:0]   mem_q [WORDS];

    logic [AW-1:0] offset_s;
    logic [2:0]    lane_s;
    logic [5:0]    shift_s;
    logic [PW-1:0] widx_s;
    logic [63:0]   size_mask_s;
    logic          shape_ok_s;
    logic          legal_s;
    logic          ready_s;
    logic [63:0]   rd_word_s;
    logic [63:0]   lane_mask_s;
    logic [63:0]   wr_word_s;
    logic          do_write_s;
    logic          fault_s;

    // Upper address bits are dropped here, which is what makes addresses alias.
    assign offset_s = address[AW-1:0];
    assign lane_s   = offset_s[2:0];
    assign shift_s  = {lane_s, 3'b000};
    assign widx_s   = PW'(offset_s >> 3);

    // Size decode: byte mask for the transfer and natural-alignment check.
    always_comb begin
        size_mask_s = 64'd0;
        shape_ok_s  = 1'b0;
        case (xfer_size)
            4'd1: begin
                size_mask_s = 64'h0000_0000_0000_00FF;
                shape_ok_s  = 1'b1;
            end
            4'd2: begin
                size_mask_s = 64'h0000_0000_0000_FFFF;
                shape_ok_s  = (lane_s[0] == 1'b0);
            end
            4'd4: begin
                size_mask_s = 64'h0000_0000_FFFF_FFFF;
                shape_ok_s  = (lane_s[1:0] == 2'b00);
            end
            4'd8: begin
                size_mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
                shape_ok_s  = (lane_s == 3'b000);
            end
            default: begin
                size_mask_s = 64'd0;
                shape_ok_s  = 1'b0;
            end
        endcase
    end

    assign legal_s     = shape_ok_s && !(write_enable && read_enable);
    assign ready_s     = !rst && (state_q == ST_READY);
    assign rd_word_s   = mem_q[widx_s];
    assign lane_mask_s = size_mask_s << shift_s;
    // Read-modify-write of the addressed word: only the selected lanes change.
    assign wr_word_s   = (rd_word_s & ~lane_mask_s) | ((write_data << shift_s) & lane_mask_s);
    assign do_write_s  = write_enable && ready_s && legal_s;
    assign fault_s     = (read_enable || write_enable) && ready_s && !legal_s;

    assign read_data = (read_enable && ready_s && legal_s)
                     ? ((rd_word_s >> shift_s) & size_mask_s) : 64'd0;
    assign busy      = (state_q == ST_CLEAR);
    assign err       = err_q;
    assign err_addr  = err_addr_q;

    // Clear FSM next state: walk the pointer across every word once.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + PW'(1);
                if (ptr_q == PW'(WORDS - 1)) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    // Clear FSM state and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Storage array: zero-fill during clear, otherwise accept legal stores.
    // Deliberately has no reset branch so contents can survive reset.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == ST_CLEAR)) begin
            mem_q[ptr_q] <= 64'd0;
        end else if (do_write_s) begin
            mem_q[widx_s] <= wr_word_s;
        end
    end

    // Sticky error capture; only the first faulting address is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q      <= 1'b0;
            err_addr_q <= 64'd0;
        end else if (fault_s) begin
            err_q <= 1'b1;
            if (!err_q) begin
                err_addr_q <= address;
            end
        end
    end

endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] address;
    logic        write_enable;
    logic        read_enable;
    logic [63:0] write_data;
    logic [3:0]  xfer_size;
    logic [63:0] read_data;
    logic        busy;
    logic        err;
    logic [63:0] err_addr;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain byte array plus error state.
    logic [7:0]  ref_mem [DEPTH];
    logic        ref_err;
    logic [63:0] ref_err_addr;

    data_mem #(.DEPTH_BYTES(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst), .address(address),
        .write_enable(write_enable), .read_enable(read_enable),
        .write_data(write_data), .xfer_size(xfer_size),
        .read_data(read_data), .busy(busy), .err(err), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    function automatic bit m_legal(logic [63:0] a, logic w, logic r, logic [3:0] sz);
        int s = int'(sz);
        if (!(s == 1 || s == 2 || s == 4 || s == 8)) return 1'b0;
        if ((a % 64'(s)) != 64'd0) return 1'b0;
        return !(w && r);
    endfunction

    function automatic logic [63:0] m_read(logic [63:0] a, logic w, logic r, logic [3:0] sz);
        logic [63:0] v = 64'd0;
        int off = int'(a % 64'(DEPTH));
        if (!r || !m_legal(a, w, r, sz)) return 64'd0;
        for (int i = 0; i < int'(sz); i++) v = v | (64'(ref_mem[off + i]) << (8 * i));
        return v;
    endfunction

    // Apply the rules of one clock edge to the model (only while ready).
    task automatic model_edge();
        int off = int'(address % 64'(DEPTH));
        logic [63:0] wd = write_data;
        if (m_legal(address, write_enable, read_enable, xfer_size)) begin
            if (write_enable)
                for (int i = 0; i < int'(xfer_size); i++) ref_mem[off + i] = wd[8*i +: 8];
        end else if (write_enable || read_enable) begin
            if (!ref_err) ref_err_addr = address;
            ref_err = 1'b1;
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'd0;
        ref_err      = 1'b0;
        ref_err_addr = 64'd0;
    endtask

    task automatic drive(input logic [63:0] a, input logic w, input logic r,
                         input logic [63:0] wd, input logic [3:0] sz);
        @(negedge clk);
        address = a; write_enable = w; read_enable = r; write_data = wd; xfer_size = sz;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        drive(64'd0, 1'b0, 1'b0, 64'd0, 4'd8);
    endtask

    // Drops rst on a falling edge and counts busy cycles, bounded.
    task automatic release_and_count(output int cnt);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int cnt;
        rst = 1'b1;
        address = 64'd0; write_enable = 1'b0; read_enable = 1'b1;
        write_data = 64'd0; xfer_size = 4'd8;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL rst_busy: got %b expected 1", busy); end
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %b expected 0", err); end
        n_checks++;
        if (err_addr !== 64'd0) begin n_errors++; $display("FAIL rst_err_addr: got %h expected 0", err_addr); end
        n_checks++;
        if (read_data !== 64'd0) begin n_errors++; $display("FAIL rst_read_data: got %h expected 0", read_data); end
        release_and_count(cnt);
        n_checks++;
        if (cnt !== 8) begin n_errors++; $display("FAIL t1_busy_cycles: got %0d expected 8", cnt); end
        model_zero();
        for (int k = 0; k < 8; k++) begin
            drive(64'(k * 8), 1'b0, 1'b1, 64'd0, 4'd8);
            n_checks++;
            if (read_data !== 64'd0) begin
                n_errors++; $display("FAIL t1_zero_word%0d: got %h expected 0", k, read_data);
            end
            tick();
        end
    endtask

    task automatic test_store_load();
        drive(64'h10, 1'b1, 1'b0, 64'h1122334455667788, 4'd8);
        tick();
        drive(64'h13, 1'b0, 1'b1, 64'd0, 4'd1);
        n_checks++;
        if (read_data !== 64'h55) begin n_errors++; $display("FAIL t2_load_b: got %h expected %h", read_data, 64'h55); end
        tick();
        drive(64'h16, 1'b0, 1'b1, 64'd0, 4'd2);
        n_checks++;
        if (read_data !== 64'h1122) begin n_errors++; $display("FAIL t2_load_h: got %h expected %h", read_data, 64'h1122); end
        tick();
        drive(64'h10, 1'b0, 1'b1, 64'd0, 4'd4);
        n_checks++;
        if (read_data !== 64'h55667788) begin n_errors++; $display("FAIL t2_load_w: got %h expected %h", read_data, 64'h55667788); end
        tick();
    endtask

    task automatic test_byte_merge();
        drive(64'h11, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFAB, 4'd1);
        tick();
        drive(64'h10, 1'b0, 1'b1, 64'd0, 4'd8);
        n_checks++;
        if (read_data !== 64'h112233445566AB88) begin
            n_errors++; $display("FAIL t3_merge: got %h expected %h", read_data, 64'h112233445566AB88);
        end
        tick();
    endtask

    task automatic test_misaligned();
        drive(64'h06, 1'b1, 1'b0, 64'hDEADBEEF_CAFEF00D, 4'd4);
        tick();
        n_checks++;
        if (err !== 1'b1) begin n_errors++; $display("FAIL t4_err: got %b expected 1", err); end
        n_checks++;
        if (err_addr !== 64'h06) begin n_errors++; $display("FAIL t4_err_addr: got %h expected 6", err_addr); end
        drive(64'h00, 1'b0, 1'b1, 64'd0, 4'd8);
        n_checks++;
        if (read_data !== 64'd0) begin n_errors++; $display("FAIL t4_word0: got %h expected 0", read_data); end
        tick();
        drive(64'h08, 1'b0, 1'b1, 64'd0, 4'd8);
        n_checks++;
        if (read_data !== 64'd0) begin n_errors++; $display("FAIL t4_word1: got %h expected 0", read_data); end
        tick();
        drive(64'h08, 1'b1, 1'b0, 64'h123456, 4'd3);
        tick();
        n_checks++;
        if (err_addr !== 64'h06) begin n_errors++; $display("FAIL t4_err_addr_kept: got %h expected 6", err_addr); end
        drive(64'h08, 1'b0, 1'b1, 64'd0, 4'd8);
        n_checks++;
        if (read_data !== 64'd0) begin n_errors++; $display("FAIL t4_size3_dropped: got %h expected 0", read_data); end
        tick();
    endtask

    task automatic test_reset_during_clear();
        int cnt;
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        // Inject a misaligned store and a late store to word 0 while busy.
        while (busy === 1'b1 && cnt < 100) begin
            write_enable = (cnt == 2 || cnt == 6);
            address      = (cnt == 2) ? 64'h05 : 64'h00;
            xfer_size    = (cnt == 2) ? 4'd4 : 4'd8;
            write_data   = 64'hFFFF_FFFF_FFFF_FFFF;
            cnt++;
            @(negedge clk);
        end
        write_enable = 1'b0;
        n_checks++;
        if (cnt !== 8) begin n_errors++; $display("FAIL t5_busy_cycles: got %0d expected 8", cnt); end
        model_zero();
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL t5_err: got %b expected 0", err); end
        drive(64'h00, 1'b0, 1'b1, 64'd0, 4'd8);
        n_checks++;
        if (read_data !== 64'd0) begin n_errors++; $display("FAIL t5_store_dropped: got %h expected 0", read_data); end
        tick();
    endtask

    task automatic test_alias_rw();
        drive(64'h1000_0000_0000_0018, 1'b1, 1'b0, 64'hCAFEF00D12345678, 4'd8);
        tick();
        drive(64'h18, 1'b0, 1'b1, 64'd0, 4'd8);
        n_checks++;
        if (read_data !== 64'hCAFEF00D12345678) begin
            n_errors++; $display("FAIL t6_alias: got %h expected %h", read_data, 64'hCAFEF00D12345678);
        end
        tick();
        drive(64'h18, 1'b1, 1'b1, 64'd0, 4'd8);
        n_checks++;
        if (read_data !== 64'd0) begin n_errors++; $display("FAIL t6_rw_read: got %h expected 0", read_data); end
        tick();
        n_checks++;
        if (err !== 1'b1) begin n_errors++; $display("FAIL t6_rw_err: got %b expected 1", err); end
        n_checks++;
        if (err_addr !== 64'h18) begin n_errors++; $display("FAIL t6_rw_err_addr: got %h expected 18", err_addr); end
        drive(64'h18, 1'b0, 1'b1, 64'd0, 4'd8);
        n_checks++;
        if (read_data !== 64'hCAFEF00D12345678) begin
            n_errors++; $display("FAIL t6_rw_nowrite: got %h expected %h", read_data, 64'hCAFEF00D12345678);
        end
        tick();
    endtask

    task automatic test_random();
        int          cnt;
        logic [63:0] a, exp;
        logic [3:0]  sz;
        logic        w, r;
        int          op;
        idle();
        rst = 1'b1;
        @(posedge clk);
        release_and_count(cnt);
        n_checks++;
        if (cnt !== 8) begin n_errors++; $display("FAIL rand_busy_cycles: got %0d expected 8", cnt); end
        model_zero();
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 4) == 0) sz = 4'($urandom_range(0, 15));
            else sz = 4'(1 << $urandom_range(0, 3));
            a = {$urandom, $urandom};
            if ((sz == 4'd1 || sz == 4'd2 || sz == 4'd4 || sz == 4'd8) && $urandom_range(0, 3) != 0)
                a = a & ~(64'(sz) - 64'd1);
            op = $urandom_range(0, 9);
            w  = (op <= 3) || (op == 8);
            r  = (op >= 4 && op <= 8);
            drive(a, w, r, {$urandom, $urandom}, sz);
            exp = m_read(a, w, r, sz);
            n_checks++;
            if (read_data !== exp) begin
                n_errors++; $display("FAIL rand_read it=%0d addr=%h size=%0d: got %h expected %h", it, a, sz, read_data, exp);
            end
            tick();
            n_checks++;
            if (err !== ref_err || err_addr !== ref_err_addr) begin
                n_errors++;
                $display("FAIL rand_err it=%0d: got err=%b addr=%h expected err=%b addr=%h", it, err, err_addr, ref_err, ref_err_addr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_merge();
        test_misaligned();
        test_reset_during_clear();
        test_alias_rw();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
